prog_launcher: RTL and testbench

- Front-end sequencer that sits directly upstream of the processor top level.
- It holds the core in reset, streams operand bytes from a byte-wide valid/ready source into data memory through a dedicated write port, then releases the core.
- While the core runs, it counts cycles until the core raises done or a timeout expires, then freezes the core and reports the result.

---
 rtl/prog_launcher_pkg.sv | 22 ++
 rtl/prog_launcher.sv | 97 +++++++++
 tb/tb_prog_launcher.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_launcher_pkg.sv
// Shared types and defaults for the program launcher front-end.
// The state encoding and the load-counter sizing rule live here.
package prog_launcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam int DEF_AW      = 8;
    localparam int DEF_N_LOAD  = 32;
    localparam int DEF_CW      = 16;
    localparam int DEF_TIMEOUT = 4000;

    // One extra bit so a full 2^AW load does not alias back to zero.
    function automatic int lcnt_w(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/prog_launcher.sv
// Load-and-run sequencer: holds the core in reset while operand bytes stream into
// data memory, releases it, then times the run until done or timeout.
module prog_launcher
    import prog_launcher_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int N_LOAD  = DEF_N_LOAD,
    parameter int CW      = DEF_CW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          dm_wr_en,
    output logic [AW-1:0] dm_addr,
    output logic [7:0]    dm_wr_dat,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    localparam int LW = lcnt_w(AW);

    state_t          r_state;
    logic [LW-1:0]   r_lcnt;
    logic [CW-1:0]   r_ccnt;
    logic [CW-1:0]   r_cycles;
    logic            r_timeout;
    logic            w_load;
    logic            w_accept;

    assign w_load   = (r_state == ST_LOAD);
    assign w_accept = w_load & in_valid;

    // Write port is combinational so each accepted byte lands in the same cycle;
    // address and data are gated to zero outside LOAD.
    assign in_ready   = w_load;
    assign dm_wr_en   = w_accept;
    assign dm_addr    = w_load ? r_lcnt[AW-1:0] : '0;
    assign dm_wr_dat  = w_load ? in_data : 8'd0;
    assign core_reset = (r_state != ST_RUN);
    assign busy       = w_load | (r_state == ST_RUN);
    assign finished   = (r_state == ST_FINISH);
    assign timeout    = r_timeout;
    assign cycles     = r_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_lcnt    <= '0;
            r_ccnt    <= '0;
            r_cycles  <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FINISH: begin
                    if (start) begin
                        r_state   <= ST_LOAD;
                        r_lcnt    <= '0;
                        r_cycles  <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_lcnt <= r_lcnt + 1'b1;
                        if (r_lcnt == LW'(N_LOAD - 1)) begin
                            r_state <= ST_RUN;
                            r_ccnt  <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    // Done wins over timeout when both land in the same cycle.
                    if (core_done) begin
                        r_cycles <= r_ccnt;
                        r_state  <= ST_FINISH;
                    end else if (r_ccnt == CW'(TIMEOUT - 1)) begin
                        r_cycles  <= CW'(TIMEOUT);
                        r_timeout <= 1'b1;
                        r_state   <= ST_FINISH;
                    end else begin
                        r_ccnt <= r_ccnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_launcher.sv
// Directed bench for prog_launcher: default instance for load/run/reset scenarios,
// a small instance (AW=2, N_LOAD=4, TIMEOUT=10) for full-depth load and timeout edges.
module tb_prog_launcher;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: defaults
    logic        reset, start, in_valid, core_done;
    logic [7:0]  in_data;
    logic        in_ready, dm_wr_en, core_reset, busy, finished, timeout;
    logic [7:0]  dm_addr, dm_wr_dat;
    logic [15:0] cycles;

    prog_launcher dut_a (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wr_dat(dm_wr_dat),
        .core_reset(core_reset), .core_done(core_done), .busy(busy), .finished(finished),
        .timeout(timeout), .cycles(cycles)
    );

    // Instance B: tiny memory, short timeout
    logic        b_reset, b_start, b_valid, b_done;
    logic [7:0]  b_data;
    logic        b_ready, b_wr_en, b_core_reset, b_busy, b_finished, b_timeout;
    logic [1:0]  b_addr;
    logic [7:0]  b_wr_dat;
    logic [15:0] b_cycles;

    prog_launcher #(.AW(2), .N_LOAD(4), .CW(16), .TIMEOUT(10)) dut_b (
        .clk(clk), .reset(b_reset), .start(b_start), .in_valid(b_valid), .in_data(b_data),
        .in_ready(b_ready), .dm_wr_en(b_wr_en), .dm_addr(b_addr), .dm_wr_dat(b_wr_dat),
        .core_reset(b_core_reset), .core_done(b_done), .busy(b_busy), .finished(b_finished),
        .timeout(b_timeout), .cycles(b_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd0);
        chk({tag, "_wr_en"},      32'(dm_wr_en),   32'd0);
        chk({tag, "_addr"},       32'(dm_addr),    32'd0);
        chk({tag, "_wr_dat"},     32'(dm_wr_dat),  32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_finished"},   32'(finished),   32'd0);
        chk({tag, "_cycles"},     32'(cycles),     32'd0);
        chk({tag, "_timeout"},    32'(timeout),    32'd0);
    endtask

    task automatic b_load4(input string tag);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_valid = 1'b1;
            b_data  = 8'hC0 + 8'(i);
            #1;
            chk({tag, "_wr_en"}, 32'(b_wr_en), 32'd1);
            chk({tag, "_addr"},  32'(b_addr),  32'(i));
            chk({tag, "_dat"},   32'(b_wr_dat), 32'hC0 + 32'(i));
            tick();
        end
        b_valid = 1'b0;
        #1;
        chk({tag, "_run_core_reset"}, 32'(b_core_reset), 32'd0);
        chk({tag, "_run_ready"},      32'(b_ready),      32'd0);
    endtask

    initial begin
        int exp_a;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; core_done = 1'b0;
        b_reset = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_data = 8'h00; b_done = 1'b0;
        tick(); tick();
        reset = 1'b0; b_reset = 1'b0;

        // Idle for 5 cycles with noisy inputs that must be ignored
        in_valid = 1'b1; in_data = 8'hAA; core_done = 1'b1;
        repeat (5) tick();
        chk_reset_outs("idle");
        in_valid = 1'b0; core_done = 1'b0;

        // Full sequential load of 0x00..0x1F
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_core_reset", 32'(core_reset), 32'd1);
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            #1;
            chk("seq_wr_en", 32'(dm_wr_en), 32'd1);
            chk("seq_addr",  32'(dm_addr),  32'(i));
            chk("seq_dat",   32'(dm_wr_dat), 32'(i));
            tick();
        end
        #1;
        chk("run1_core_reset", 32'(core_reset), 32'd0);
        chk("run1_in_ready",   32'(in_ready),   32'd0);
        chk("run1_wr_en",      32'(dm_wr_en),   32'd0);
        chk("run1_busy",       32'(busy),       32'd1);
        in_valid = 1'b0;

        // start in RUN is ignored; done on the 341st RUN cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (339) tick();
        chk("run341_busy", 32'(busy), 32'd1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("done_finished",   32'(finished),   32'd1);
        chk("done_cycles",     32'(cycles),     32'd340);
        chk("done_timeout",    32'(timeout),    32'd0);
        chk("done_core_reset", 32'(core_reset), 32'd1);
        chk("done_busy",       32'(busy),       32'd0);
        core_done = 1'b1;
        repeat (3) tick();
        core_done = 1'b0;
        chk("finish_hold_cycles", 32'(cycles),   32'd340);
        chk("finish_hold_fin",    32'(finished), 32'd1);

        // Restart from FINISH clears results; load with toggling valid
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_cycles",   32'(cycles),   32'd0);
        chk("restart_finished", 32'(finished), 32'd0);
        exp_a = 0;
        for (int k = 0; k < 100 && exp_a < 32; k++) begin
            in_valid = (k % 2 == 0);
            in_data  = 8'h80 + 8'(k);
            #1;
            if (in_valid) begin
                chk("tog_wr_en", 32'(dm_wr_en), 32'd1);
                chk("tog_addr",  32'(dm_addr),  32'(exp_a));
                chk("tog_dat",   32'(dm_wr_dat), 32'h80 + 32'(k));
                exp_a++;
            end else begin
                chk("tog_idle_wr_en", 32'(dm_wr_en), 32'd0);
                chk("tog_idle_addr",  32'(dm_addr),  32'(exp_a));
            end
            tick();
        end
        in_valid = 1'b0;
        chk("tog_count", 32'(exp_a), 32'd32);
        chk("tog_run_core_reset", 32'(core_reset), 32'd0);

        // Reset in RUN, then restart and reset mid-load at byte 7
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_outs("rst_run");
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h40 + 8'(i);
            tick();
        end
        in_data = 8'h47;
        #1;
        chk("byte7_addr", 32'(dm_addr), 32'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_outs("rst_load");
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(i);
            #1;
            if (i < 2) chk("reload_addr", 32'(dm_addr), 32'(i));
            tick();
        end
        in_valid = 1'b0;
        chk("reload_run", 32'(core_reset), 32'd0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("done_first_cycles",  32'(cycles),   32'd0);
        chk("done_first_timeout", 32'(timeout),  32'd0);
        chk("done_first_fin",     32'(finished), 32'd1);

        // Instance B: full-depth load, timeout after 10 RUN cycles
        b_load4("b1");
        repeat (9) tick();
        chk("b_to_busy10", 32'(b_busy), 32'd1);
        tick();
        chk("b_to_finished", 32'(b_finished), 32'd1);
        chk("b_to_timeout",  32'(b_timeout),  32'd1);
        chk("b_to_cycles",   32'(b_cycles),   32'd10);

        // Done on the 10th cycle beats the timeout
        b_load4("b2");
        chk("b2_cleared_timeout", 32'(b_timeout), 32'd0);
        repeat (9) tick();
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        chk("b_done10_finished", 32'(b_finished), 32'd1);
        chk("b_done10_timeout",  32'(b_timeout),  32'd0);
        chk("b_done10_cycles",   32'(b_cycles),   32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
